// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues sequential word fetches to an instruction memory that uses a
// request/grant handshake with in-order, variable-latency responses. Returned
// instructions are queued in a 2-entry {instr,pc} FIFO whose head drives the
// decode interface directly from registers. A redirect from downstream reloads
// the PC, flushes the FIFO and arranges for responses that are still in
// flight to be dropped when they return.
//
// Parameters
//   RESET_PC        first fetch address after reset
//   NOP_INSTR       instruction shown on id_instr_o when nothing is held
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   imem_req_o      fetch request valid
//   imem_addr_o     fetch byte address (word aligned)
//   imem_gnt_i      request accepted when imem_req_o & imem_gnt_i
//   imem_rvalid_i   response valid, one per grant, in order
//   imem_rdata_i    instruction word of the response
//   redirect_i      taken branch/jump, flushes fetch
//   redirect_pc_i   new fetch address (bits [1:0] ignored)
//   id_valid_o      instruction available to decode
//   id_instr_o      instruction word (NOP_INSTR when not valid)
//   id_pc_o         address of id_instr_o (0 when not valid)
//   id_ready_i      decode accepts; transfer when id_valid_o & id_ready_i
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q, pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   drop_q, drop_d;
  logic [1:0]   count_q, count_d;
  fetch_entry_t head_q, tail_q;

  logic         grant;
  logic         pop;
  logic         push;
  logic [2:0]   occupancy;
  logic [1:0]   keep_cnt;
  fetch_entry_t resp_entry;

  // The two low bits of the redirect target are forced to zero, never used.
  logic         unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign pop = (count_q != 2'd0) & id_ready_i;

  // Slots already committed: requests in flight plus instructions held,
  // minus the one leaving this cycle. Dropped responses still count since
  // they occupy the memory pipeline until they return.
  assign occupancy  = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
  assign imem_req_o = rst_ni & ~redirect_i & (occupancy < 3'd2);
  assign grant      = imem_req_o & imem_gnt_i;

  assign push = imem_rvalid_i & (drop_q == 2'd0) & ~redirect_i;

  // In-flight requests that will be kept are the most recent grants, issued
  // back to back from the current PC, so the returning word's address is
  // PC minus four per kept request.
  assign keep_cnt         = outstanding_q - drop_q;
  assign resp_entry.instr = imem_rdata_i;
  assign resp_entry.pc    = pc_q - {28'd0, keep_cnt, 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;

    if (grant && !imem_rvalid_i) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!grant && imem_rvalid_i) begin
      outstanding_d = outstanding_q - 2'd1;
    end

    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      count_d = 2'd0;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d  = outstanding_q - {1'b0, imem_rvalid_i};
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rvalid_i && drop_q != 2'd0) begin
        drop_d = drop_q - 2'd1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      count_q       <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
    end
  end

  // NOTE: FIFO payload registers have no reset; count_q alone says which
  // entries are meaningful and the outputs are masked while it is zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      if (pop) begin
        if (count_q == 2'd2) begin
          head_q <= tail_q;
          tail_q <= resp_entry;
        end else begin
          head_q <= resp_entry;
        end
      end else if (count_q == 2'd0) begin
        head_q <= resp_entry;
      end else begin
        tail_q <= resp_entry;
      end
    end else if (pop) begin
      head_q <= tail_q;
    end
  end

  assign imem_addr_o = pc_q;
  assign id_valid_o  = (count_q != 2'd0);
  assign id_instr_o  = id_valid_o ? head_q.instr : NOP_INSTR;
  assign id_pc_o     = id_valid_o ? head_q.pc : 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// A behavioural memory (queue of pending requests with random latency) and a
// queue of instructions expected at decode are kept by the bench. Outputs are
// compared every cycle on the falling clock edge; inputs are driven there too.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  always #5 clk_i = ~clk_i;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_ready_i   (id_ready_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_entry_t;

  mem_req_t    mem_q[$];   // granted requests not yet answered
  exp_entry_t  exp_q[$];   // instructions expected at decode, in order
  logic [31:0] m_pc;
  int          m_drop;
  int          cyc;
  int          last_due;
  int          n_xfer;
  int          n_checks;
  int          n_errors;

  int p_gnt, p_ready, p_redir, max_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    m_pc     = RESET_PC;
    m_drop   = 0;
    last_due = 0;
  endtask

  task automatic drive_idle();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string when);
    check({when, " req"},   32'(imem_req_o), 32'd0);
    check({when, " addr"},  imem_addr_o,     RESET_PC);
    check({when, " valid"}, 32'(id_valid_o), 32'd0);
    check({when, " instr"}, id_instr_o,      NOP_INSTR);
    check({when, " pc"},    id_pc_o,         32'h0);
  endtask

  // One clock cycle: compare registered outputs, drive inputs, compare the
  // request, then advance the reference model with what happened.
  task automatic step(input bit force_redir, input logic [31:0] force_pc);
    bit          rv, rd, pp, gr, exp_req;
    logic [31:0] rpc, raddr;
    int          lat, due;

    @(negedge clk_i);
    cyc++;

    if (exp_q.size() > 0) begin
      check("id_valid", 32'(id_valid_o), 32'd1);
      check("id_instr", id_instr_o, exp_q[0].instr);
      check("id_pc",    id_pc_o,    exp_q[0].pc);
    end else begin
      check("id_valid", 32'(id_valid_o), 32'd0);
      check("id_instr", id_instr_o, NOP_INSTR);
      check("id_pc",    id_pc_o,    32'h0);
    end
    check("imem_addr", imem_addr_o, m_pc);

    rd  = force_redir || ($urandom_range(99) < p_redir);
    rpc = force_redir ? force_pc : $urandom;
    rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);

    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    id_ready_i    = ($urandom_range(99) < p_ready);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mem_q[0].addr) : $urandom;
    #1;

    pp      = (exp_q.size() > 0) && id_ready_i;
    exp_req = !rd && (mem_q.size() + exp_q.size() - int'(pp) < 2);
    check("imem_req", 32'(imem_req_o), 32'(exp_req));
    gr = imem_req_o && imem_gnt_i;

    if (pp) begin
      exp_q.pop_front();
      n_xfer++;
    end
    if (rv) begin
      raddr = mem_q[0].addr;
      mem_q.pop_front();
      if (!rd) begin
        if (m_drop > 0) m_drop--;
        else exp_q.push_back('{instr: mem_word(raddr), pc: raddr});
      end
    end
    if (rd) begin
      exp_q.delete();
      m_drop = mem_q.size();
      m_pc   = rpc & ~32'h3;
    end
    if (gr) begin
      lat = $urandom_range(max_lat, 1);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{addr: m_pc, due: due});
      last_due = due;
      m_pc     = m_pc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int l);
    p_gnt = g; p_ready = r; p_redir = d; max_lat = l;
  endtask

  initial begin
    int xfer_start;
    n_checks = 0;
    n_errors = 0;
    n_xfer   = 0;
    cyc      = 0;
    rst_ni   = 1'b0;
    drive_idle();
    model_reset();

    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Full-rate streaming: one transfer per cycle once the pipe is primed.
    set_knobs(100, 100, 0, 1);
    run(5);
    xfer_start = n_xfer;
    run(20);
    check("throughput", 32'(n_xfer - xfer_start), 32'd20);

    // Consumer stalls: fetch stops after filling, then drains in order.
    set_knobs(100, 0, 0, 1);
    run(8);
    set_knobs(100, 100, 0, 1);
    run(8);

    // Redirect with responses in flight, then a misaligned target.
    set_knobs(100, 0, 0, 3);
    run(3);
    step(1'b1, 32'h0000_0100);
    set_knobs(100, 100, 0, 3);
    run(10);
    step(1'b1, 32'h0000_0203);
    run(4);

    // Grant withheld: address held, nothing fetched.
    set_knobs(0, 100, 0, 1);
    run(6);

    // Back-to-back redirects.
    set_knobs(100, 50, 0, 2);
    run(3);
    step(1'b1, 32'h0000_0400);
    step(1'b1, 32'h0000_0800);
    run(6);

    // Random traffic.
    set_knobs(70, 70, 8, 3);
    run(400);

    // Reset asserted mid-stream, between clock edges.
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    set_knobs(100, 100, 0, 1);
    run(10);
    set_knobs(60, 60, 6, 3);
    run(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
